// File: rtl/snn_pkg.sv
// Shared SNN front-end types: AER address width and receiver FSM states.
// No ports; imported by the AER receive path and its interface.
package snn_pkg;

    localparam int IMAGE_SIZE      = 256;
    localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
    localparam int AER_ADDR_W      = IMAGE_SIZE_BITS + 2;

    typedef enum logic {
        IDLE        = 1'b0,
        WAIT_REQ_LO = 1'b1
    } rx_state_t;

endpackage

// File: rtl/aer_rx_buffer_if.sv
// AER link plus event stream bundle for the AER receive buffer.
// Ports: AERIN_ADDR/REQ/ACK (4-phase link), EVT_ADDR/VALID/READY (stream).
interface aer_rx_buffer_if #(
    parameter int ADDR_W = snn_pkg::AER_ADDR_W
);

    logic [ADDR_W-1:0] AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;
    logic [ADDR_W-1:0] EVT_ADDR;
    logic              EVT_VALID;
    logic              EVT_READY;

    // slave: the receive buffer itself
    modport slave (
        input  AERIN_ADDR,
        input  AERIN_REQ,
        input  EVT_READY,
        output AERIN_ACK,
        output EVT_ADDR,
        output EVT_VALID
    );

    // master: transmitter and core side
    modport master (
        output AERIN_ADDR,
        output AERIN_REQ,
        output EVT_READY,
        input  AERIN_ACK,
        input  EVT_ADDR,
        input  EVT_VALID
    );

endinterface

// File: rtl/sync_fifo.sv
// Level-counted synchronous FIFO, first-word-fall-through head.
// Ports: clk, rst_n, push, pop, din, dout, level, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered level only
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // head reads as zero while empty so reset shows a clean bus
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/aer_rx_buffer.sv
// AER 4-phase receiver: syncs REQ, ACKs into a FIFO, counts events.
// Ports: CLK, RST_N, bus (AER link + event stream), CLEAR, EVT_COUNT, FIFO_LEVEL.
module aer_rx_buffer
    import snn_pkg::*;
#(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int FIFO_DEPTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_BITS        = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    aer_rx_buffer_if.slave              bus,
    input  logic                        CLEAR,
    output logic [CNT_BITS-1:0]         EVT_COUNT,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

    localparam int ADDR_W = IMAGE_SIZE_BITS + 2;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    rx_state_t              state;
    rx_state_t              next_state;
    logic                   ack_q;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    // REQ synchronizer; ADDR is only sampled once req_s is high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            req_sync <= '0;
        else
            req_sync <= {req_sync[SYNC_STAGES-2:0], bus.AERIN_REQ};
    end

    assign req_s = req_sync[SYNC_STAGES-1];

    // state register, ACK registered alongside it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= next_state;
            ack_q <= (next_state == WAIT_REQ_LO);
        end
    end

    // next-state: a full FIFO holds the handshake in IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (req_s && !fifo_full)
                    next_state = WAIT_REQ_LO;
            WAIT_REQ_LO:
                if (!req_s)
                    next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    // outputs: one push per handshake, on the IDLE exit
    always_comb begin
        push = 1'b0;
        unique case (1'b1)
            (state == IDLE):
                push = req_s && !fifo_full;
            default:
                push = 1'b0;
        endcase
    end

    assign bus.AERIN_ACK = ack_q;

    // CLEAR wins over a same-cycle push; count saturates
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            EVT_COUNT <= '0;
        else if (CLEAR)
            EVT_COUNT <= '0;
        else if (push && (EVT_COUNT != '1))
            EVT_COUNT <= EVT_COUNT + 1'b1;
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (bus.EVT_READY),
        .din   (bus.AERIN_ADDR),
        .dout  (bus.EVT_ADDR),
        .level (FIFO_LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.EVT_VALID = !fifo_empty;

endmodule

// File: tb/tb_aer_rx_buffer.sv
// Self-checking bench for aer_rx_buffer: handshake timing, order, backpressure,
// CLEAR, saturation (CNT_BITS=4 instance) and asynchronous reset.
module tb_aer_rx_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [15:0] evt_count;
    logic [3:0]  fifo_level;
    logic [3:0]  evt_count4;
    logic [3:0]  fifo_level4;

    int errors = 0;
    int checks = 0;
    int max_lvl = 0;
    bit mon_lvl = 1'b0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    aer_rx_buffer_if bus ();
    aer_rx_buffer_if bus4 ();

    aer_rx_buffer dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .bus        (bus),
        .CLEAR      (clear),
        .EVT_COUNT  (evt_count),
        .FIFO_LEVEL (fifo_level)
    );

    aer_rx_buffer #(.CNT_BITS(4)) dut4 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .bus        (bus4),
        .CLEAR      (1'b0),
        .EVT_COUNT  (evt_count4),
        .FIFO_LEVEL (fifo_level4)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted pop must match the oldest offered address
    always @(negedge clk) begin
        if (rst_n && bus.EVT_VALID && bus.EVT_READY) begin
            if (q.size() == 0)
                check("spurious_pop", 32'(bus.EVT_ADDR), 32'hffff_ffff);
            else
                check("order", 32'(bus.EVT_ADDR), 32'(q.pop_front()));
        end
        if (mon_lvl && (32'(fifo_level) > max_lvl))
            max_lvl = 32'(fifo_level);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(logic val, string tag);
        int n = 0;
        while (bus.AERIN_ACK !== val && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(bus.AERIN_ACK), 32'(val));
    endtask

    task automatic start_req(logic [9:0] a);
        bus.AERIN_ADDR = a;
        bus.AERIN_REQ  = 1'b1;
        q.push_back(a);
    endtask

    task automatic send(logic [9:0] a);
        start_req(a);
        wait_ack(1'b1, "ack_hi");
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "ack_lo");
    endtask

    task automatic send4(logic [9:0] a);
        int n = 0;
        bus4.AERIN_ADDR = a;
        bus4.AERIN_REQ  = 1'b1;
        while (bus4.AERIN_ACK !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("ack4_hi", 32'(bus4.AERIN_ACK), 32'd1);
        bus4.AERIN_REQ = 1'b0;
        n = 0;
        while (bus4.AERIN_ACK !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        check("ack4_lo", 32'(bus4.AERIN_ACK), 32'd0);
    endtask

    task automatic drain();
        bus.EVT_READY = 1'b1;
        for (int k = 0; k < 100 && q.size() != 0; k++)
            step();
        step();
        check("drain_q", 32'(q.size()), 32'd0);
        check("drain_lvl", 32'(fifo_level), 32'd0);
        bus.EVT_READY = 1'b0;
    endtask

    // single event with exact cycle timing; FIFO empty, count 0 on entry
    task automatic single_event();
        step();
        start_req(10'h05A);
        repeat (3) @(negedge clk);
        check("se_ack_early", 32'(bus.AERIN_ACK), 32'd0);
        @(negedge clk);
        check("se_ack_rise", 32'(bus.AERIN_ACK), 32'd1);
        @(negedge clk);
        check("se_valid", 32'(bus.EVT_VALID), 32'd1);
        check("se_addr", 32'(bus.EVT_ADDR), 32'h05A);
        check("se_level", 32'(fifo_level), 32'd1);
        step();
        bus.AERIN_REQ = 1'b0;
        repeat (3) @(negedge clk);
        check("se_ack_hold", 32'(bus.AERIN_ACK), 32'd1);
        @(negedge clk);
        check("se_ack_fall", 32'(bus.AERIN_ACK), 32'd0);
        check("se_count", 32'(evt_count), 32'd1);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.AERIN_ADDR  = '0;
        bus.AERIN_REQ   = 1'b0;
        bus.EVT_READY   = 1'b0;
        bus4.AERIN_ADDR = '0;
        bus4.AERIN_REQ  = 1'b0;
        bus4.EVT_READY  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.AERIN_ACK), 32'd0);
        check("rst_valid", 32'(bus.EVT_VALID), 32'd0);
        check("rst_addr", 32'(bus.EVT_ADDR), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;

        single_event();

        // stream with core always ready
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.EVT_READY = 1'b1;
        max_lvl = 0;
        mon_lvl = 1'b1;
        for (int i = 0; i < 20; i++)
            send(10'(i));
        repeat (4) step();
        mon_lvl = 1'b0;
        check("stream_count", 32'(evt_count), 32'd20);
        check("stream_lvl_le1", 32'(max_lvl <= 1), 32'd1);
        check("stream_q", 32'(q.size()), 32'd0);

        // backpressure, then full FIFO with a one-cycle pop
        bus.EVT_READY = 1'b0;
        for (int i = 0; i < 8; i++)
            send(10'(i));
        step();
        check("bp_level8", 32'(fifo_level), 32'd8);
        start_req(10'd8);
        repeat (10) step();
        check("bp_ack_held", 32'(bus.AERIN_ACK), 32'd0);
        check("bp_level_held", 32'(fifo_level), 32'd8);
        bus.EVT_READY = 1'b1;
        step();
        bus.EVT_READY = 1'b0;
        @(negedge clk);
        check("pop_level7", 32'(fifo_level), 32'd7);
        check("pop_ack_lo", 32'(bus.AERIN_ACK), 32'd0);
        @(negedge clk);
        check("push_level8", 32'(fifo_level), 32'd8);
        check("push_ack_hi", 32'(bus.AERIN_ACK), 32'd1);
        step();
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "bp_ack_lo");
        drain();

        // CLEAR, then CLEAR coincident with a push
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.EVT_READY = 1'b1;
        for (int i = 0; i < 5; i++)
            send(10'h100 + 10'(i));
        repeat (3) step();
        check("clr_count5", 32'(evt_count), 32'd5);
        bus.EVT_READY = 1'b0;
        start_req(10'h3C3);
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check("clr_push_count", 32'(evt_count), 32'd0);
        check("clr_push_level", 32'(fifo_level), 32'd1);
        check("clr_push_ack", 32'(bus.AERIN_ACK), 32'd1);
        step();
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "clr_ack_lo");
        check("clr_count_after", 32'(evt_count), 32'd0);
        drain();

        // asynchronous reset mid-handshake
        send(10'h011);
        send(10'h022);
        start_req(10'h033);
        wait_ack(1'b1, "mid_ack_hi");
        check("mid_level3", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(bus.AERIN_ACK), 32'd0);
        check("arst_valid", 32'(bus.EVT_VALID), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_count", 32'(evt_count), 32'd0);
        q.delete();
        bus.AERIN_REQ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        single_event();

        // saturation on the 4-bit counter instance
        for (int i = 0; i < 14; i++)
            send4(10'(i));
        step();
        check("sat_count14", 32'(evt_count4), 32'd14);
        for (int i = 14; i < 17; i++)
            send4(10'(i));
        step();
        check("sat_count15", 32'(evt_count4), 32'd15);
        check("sat_level", 32'(fifo_level4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aer_rx_buffer.md
Name: aer_rx_buffer

Overview:
- Downstream neighbour of the input interface: terminates the 4-phase AER link (ADDR/REQ/ACK) driven by the encoder-side AER transmitter.
- Buffers received addresses in a small FIFO and presents them to the SNN core over a valid/ready stream.
- Counts events per image, giving the controller a per-inference spike-count observable.
- Applies backpressure by withholding ACK when the FIFO is full; no event is ever dropped.

Parameters:
- IMAGE_SIZE, 256, number of input pixels/neurons.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index width; AER address width is IMAGE_SIZE_BITS+2.
- FIFO_DEPTH, 8, entries; must be a power of two, ≥2.
- SYNC_STAGES, 2, flops in the REQ synchronizer; ≥2.
- CNT_BITS, 16, event counter width.

Ports:
- CLK  in  1  single clock.
- RST_N  in  1  asynchronous, active-low reset.
- AERIN_ADDR  in  IMAGE_SIZE_BITS+2  event address; stable while AERIN_REQ is high.
- AERIN_REQ  in  1  4-phase request from the transmitter.
- AERIN_ACK  out  1  4-phase acknowledge, registered.
- EVT_ADDR  out  IMAGE_SIZE_BITS+2  FIFO head address.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_READY  in  1  core accepts head; pop when EVT_VALID && EVT_READY.
- CLEAR  in  1  synchronous pulse at NEW_IMAGE; zeroes the event counter.
- EVT_COUNT  out  CNT_BITS  events accepted since the last CLEAR/reset; saturates at all-ones.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (RST_N low, async):
  - AERIN_ACK=0, EVT_VALID=0, EVT_ADDR=0, EVT_COUNT=0, FIFO_LEVEL=0.
  - FSM goes to IDLE; synchronizer flops are cleared.
  - Reset release is synchronous to CLK on the deassertion edge.
- REQ synchronizer: AERIN_REQ passes through SYNC_STAGES flops, giving req_s. AERIN_ADDR is not synchronized; it is sampled only once req_s=1, and the protocol guarantees stability.
- FSM states: IDLE, WAIT_REQ_LO.
  - IDLE, req_s=1 and FIFO not full: write AERIN_ADDR into the FIFO, set ACK=1, increment EVT_COUNT, go to WAIT_REQ_LO.
  - IDLE, req_s=1 and FIFO full: stay in IDLE with ACK=0; this is the backpressure case.
  - WAIT_REQ_LO, req_s=0: ACK=0, return to IDLE.
- Latency with SYNC_STAGES=2:
  - AERIN_ACK rises on the 3rd CLK edge after REQ rises, and falls on the 3rd edge after REQ falls.
  - Minimum handshake period is 6 cycles.
- Push and count rules:
  - The full check uses the registered level; there is no same-cycle bypass.
  - If the FIFO is full and a pop occurs in the same cycle, the pending push happens one cycle later.
  - At most one push per handshake; a new event is only possible after REQ has gone low and back high.
- FIFO:
  - First-word-fall-through: EVT_VALID rises the cycle after the push edge; EVT_ADDR is the head entry.
  - Pop on EVT_VALID && EVT_READY.
  - Simultaneous push and pop with 0<level<FIFO_DEPTH leaves the level unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty is derived from a level counter.
  - Pop when empty is ignored.
- EVT_COUNT:
  - +1 per push; saturates.
  - CLEAR takes priority over a same-cycle increment, so the result is 0 and that event is not counted.
  - CLEAR does not flush the FIFO or disturb the handshake.
- Reset mid-handshake: ACK drops immediately (async). The transmitter is reset by the same RST_N, so no recovery logic is required.
- Width rule: addresses pass through unmodified; no decoding of the top 2 bits is done in this block.

Decomposition:
- Shared package snn_pkg holds:
  - localparam AER_ADDR_W = IMAGE_SIZE_BITS+2;
  - the FSM enum rx_state_t {IDLE, WAIT_REQ_LO}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/din/dout/level/full/empty), reused by the output AER path later.
- The synchronizer is inline.

Test Plan:
- Single event: after reset, REQ↑ with ADDR=0x05A.
  - Expect ACK↑ 3 cycles later; EVT_VALID=1 and EVT_ADDR=0x05A one cycle later.
  - Release REQ; expect ACK↓ 3 cycles later. EVT_COUNT=1.
- Stream: 20 back-to-back handshakes with ADDR=0..19 and EVT_READY=1.
  - Core sees 0..19 in order, no duplicates; EVT_COUNT=20; FIFO_LEVEL ≤1.
- Backpressure: EVT_READY=0, 9 events offered.
  - First 8 ACKed, FIFO_LEVEL=8; 9th REQ held with ACK=0.
  - Raise EVT_READY one cycle; expect the 9th push and ACK on the following edges; order 0..8 preserved.
- Full with simultaneous pop: FIFO full, REQ pending, EVT_READY pulsed.
  - Level goes 8→7→8; push occurs exactly one cycle after the pop.
- CLEAR: EVT_COUNT=5, then CLEAR coincident with a push.
  - EVT_COUNT=0 next cycle; the FIFO still holds the pushed event.
  - Saturation: preload the count near max (CNT_BITS=4 build), 17 events → 15.
- Reset mid-operation: RST_N low while ACK=1 and level=3.
  - ACK=0, EVT_VALID=0, level=0 with no clock edge needed; after release, a fresh single event behaves as in the first scenario.
